core_scheduler: RTL

Per-core instruction sequencer for the TinyGPU compute core. It steps every thread in the core through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE. It issues the write-enable strobes for the NZP flag registers and the register files, and it owns the core program counter. It sits between the block dispatcher (start/done), the fetcher, and the per-thread LSUs.

---
 rtl/core_sched_pkg.sv | 17 +
 rtl/core_scheduler.sv | 85 ++++++++
 2 files changed

// File: rtl/core_sched_pkg.sv
// rtl/core_sched_pkg.sv - shared state encoding for the per-core instruction sequencer
package core_sched_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_REQUEST = 3'd3,
        ST_WAIT    = 3'd4,
        ST_EXECUTE = 3'd5,
        ST_UPDATE  = 3'd6,
        ST_DONE    = 3'd7
    } core_state_t;

endpackage

// File: rtl/core_scheduler.sv
// rtl/core_scheduler.sv - per-core FETCH..UPDATE sequencer owning the core PC and retire counter
module core_scheduler
    import core_sched_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    output logic               done,
    output logic               fetcher_req,
    input  logic               fetcher_done,
    input  logic               dec_mem_rd,
    input  logic               dec_mem_wr,
    input  logic               dec_nzp_we,
    input  logic               dec_reg_we,
    input  logic               dec_ret,
    output logic               lsu_req,
    input  logic [THREADS-1:0] lsu_busy,
    output logic               nzp_we,
    output logic               reg_we,
    input  logic [PC_W-1:0]    next_pc,
    output logic [PC_W-1:0]    pc_current,
    output logic [STATE_W-1:0] core_state,
    output logic [CNT_W-1:0]   instr_retired
);

    core_state_t state_q, state_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            pc_current    <= '0;
            instr_retired <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_UPDATE) begin
                if (instr_retired != {CNT_W{1'b1}})
                    instr_retired <= instr_retired + CNT_W'(1);
                // RET leaves the PC pointing at itself
                if (!dec_ret)
                    pc_current <= next_pc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_FETCH;
            ST_FETCH:   if (fetcher_done) state_d = ST_DECODE;
            ST_DECODE:  state_d = ST_REQUEST;
            ST_REQUEST: state_d = ST_WAIT;
            ST_WAIT:    if (~|lsu_busy) state_d = ST_EXECUTE;
            ST_EXECUTE: state_d = ST_UPDATE;
            ST_UPDATE:  state_d = dec_ret ? ST_DONE : ST_FETCH;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Strobes depend only on the registered state and the held decode fields
    always_comb begin
        done        = 1'b0;
        fetcher_req = 1'b0;
        lsu_req     = 1'b0;
        nzp_we      = 1'b0;
        reg_we      = 1'b0;
        case (state_q)
            ST_FETCH:   fetcher_req = 1'b1;
            ST_REQUEST: lsu_req     = dec_mem_rd | dec_mem_wr;
            ST_UPDATE: begin
                nzp_we = dec_nzp_we;
                reg_we = dec_reg_we;
            end
            ST_DONE:    done        = 1'b1;
            default: ;
        endcase
    end

    assign core_state = state_q;

endmodule
